paddle_ctrl: RTL

//  Parametrised paddle controller for the pong datapath: one instance per player.

---
 rtl/pong_pkg.sv | 34 +++
 rtl/pb_debounce.sv | 33 +++
 rtl/paddle_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared pong datapath constants, coordinate/zone types and zone helper.
package pong_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = 10;
  localparam int ZONE_W   = 2;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [ZONE_W-1:0]  zone_t;

  localparam zone_t ZONE_TOP  = 2'd0;
  localparam zone_t ZONE_UMID = 2'd1;
  localparam zone_t ZONE_LMID = 2'd2;
  localparam zone_t ZONE_BOT  = 2'd3;

  // Quarter index of off within span, i.e. off*4/span, without a divider.
  function automatic zone_t zone_of(
    input logic [10:0] off,
    input logic [10:0] span
  );
    logic [12:0] o4;
    logic [12:0] s1;
    logic [12:0] s2;
    logic [12:0] s3;
    o4 = {off, 2'b00};
    s1 = {2'b00, span};
    s2 = s1 + s1;
    s3 = s2 + s1;
    if (o4 < s1) return ZONE_TOP;
    else if (o4 < s2) return ZONE_UMID;
    else if (o4 < s3) return ZONE_LMID;
    else return ZONE_BOT;
  endfunction
endpackage

// File: rtl/pb_debounce.sv
// Push-button debouncer: 2-flop synchroniser then a stable-count filter.
module pb_debounce #(
  parameter logic [19:0] DB_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic db
);
  logic        s0;
  logic        s1;
  logic [19:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0  <= 1'b0;
      s1  <= 1'b0;
      cnt <= '0;
      db  <= 1'b0;
    end else begin
      s0 <= pb;
      s1 <= s0;
      if (s1 == db) begin
        cnt <= '0;
      end else if (cnt >= DB_CYCLES - 20'd1) begin
        db  <= s1;
        cnt <= '0;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end
endmodule

// File: rtl/paddle_ctrl.sv
// Per-player paddle: debounced stepping, clamping and registered hit/zone.
// Optional ball-tracking mode is enabled by defining PADDLE_AI_EN.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter coord_t      X_POS     = 10'd20,
  parameter coord_t      HALF_W    = 10'd5,
  parameter coord_t      HALF_H    = 10'd50,
  parameter coord_t      STEP      = 10'd10,
  parameter coord_t      Y_INIT    = 10'd240,
  parameter coord_t      Y_MIN     = 10'd50,
  parameter coord_t      Y_MAX     = 10'd430,
  parameter logic [19:0] MOVE_DIV  = 20'd416667,
  parameter logic [19:0] DB_CYCLES = 20'd500000
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   pb_up,
  input  logic   pb_dn,
  input  coord_t hsp,
  input  coord_t vsp,
  output coord_t y,
  output logic   hit,
  output zone_t  hit_zone,
  output logic   moving
`ifdef PADDLE_AI_EN
  ,
  input  coord_t ball_y,
  input  logic   ai_mode
`endif
);
  localparam logic [10:0] XP   = {1'b0, X_POS};
  localparam logic [10:0] HW   = {1'b0, HALF_W};
  localparam logic [10:0] HH   = {1'b0, HALF_H};
  localparam logic [10:0] ST   = {1'b0, STEP};
  localparam logic [10:0] YMIN = {1'b0, Y_MIN};
  localparam logic [10:0] YMAX = {1'b0, Y_MAX};

  logic        up_d;
  logic        dn_d;
  logic [19:0] cnt;
  logic        tick;
  logic        go_up;
  logic        go_dn;
  coord_t      y_next;
  logic [10:0] y11;
  logic [10:0] h11;
  logic [10:0] v11;
  logic        in_rect;
  zone_t       zone;

  pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .pb(pb_up), .db(up_d)
  );

  pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
    .clk(clk), .rst(rst), .pb(pb_dn), .db(dn_d)
  );

  assign tick = (cnt == MOVE_DIV - 20'd1);
  assign y11  = {1'b0, y};
  assign h11  = {1'b0, hsp};
  assign v11  = {1'b0, vsp};

`ifdef PADDLE_AI_EN
  localparam logic [10:0] HS = {1'b0, STEP >> 1};
  logic [10:0] b11;
  assign b11   = {1'b0, ball_y};
  assign go_up = ai_mode ? (b11 + HS < y11) : (up_d & ~dn_d);
  assign go_dn = ai_mode ? (b11 > y11 + HS) : (dn_d & ~up_d);
`else
  assign go_up = up_d & ~dn_d;
  assign go_dn = dn_d & ~up_d;
`endif

  always_comb begin
    y_next = y;
    if (tick) begin
      unique case (1'b1)
        go_up:   y_next = (y11 < YMIN + ST) ? Y_MIN : y - STEP;
        go_dn:   y_next = (y11 + ST > YMAX) ? Y_MAX : y + STEP;
        default: y_next = y;
      endcase
    end
  end

  // Subtraction-free bounds so edge-of-screen scans cannot underflow.
  always_comb begin
    in_rect = (h11 + HW >= XP) && (h11 < XP + HW) &&
              (v11 + HH >= y11) && (v11 < y11 + HH);
    zone    = in_rect ? zone_of(v11 + HH - y11, HH + HH) : ZONE_TOP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      y        <= Y_INIT;
      moving   <= 1'b0;
      hit      <= 1'b0;
      hit_zone <= ZONE_TOP;
    end else begin
      cnt      <= tick ? 20'd0 : cnt + 20'd1;
      y        <= y_next;
      moving   <= (y_next != y);
      hit      <= in_rect;
      hit_zone <= zone;
    end
  end
endmodule
